i3c_frombus_cdc_fifo: RTL and testbench

//  Parametrised inbound (bus->system) FIFO for the I3C engine: SCL-domain byte writes, CLK-domain reads.

---
 rtl/i3c_frombus_cdc_fifo_if.sv | 28 ++
 rtl/i3c_frombus_cdc_fifo.sv | 165 ++++++++++++++++
 tb/tb_i3c_frombus_cdc_fifo.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i3c_frombus_cdc_fifo_if.sv
// Inbound FIFO bus bundle: SCL-side byte push and CLK-side
// presented-byte handshake between receive engine and RX regs.
interface i3c_frombus_cdc_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] fb_datab;
  logic              fb_datab_done;
  logic              fb_datab_err;
  logic              fb_data_use;
  logic              notify_fb_ready;
  logic [DATA_W-1:0] notify_fb_data;
  logic              notify_fb_err;
  logic              notify_fb_ack;

  modport master (
    output fb_datab, fb_datab_done, fb_datab_err,
    output notify_fb_ack,
    input  fb_data_use,
    input  notify_fb_ready, notify_fb_data, notify_fb_err
  );

  modport slave (
    input  fb_datab, fb_datab_done, fb_datab_err,
    input  notify_fb_ack,
    output fb_data_use,
    output notify_fb_ready, notify_fb_data, notify_fb_err
  );
endinterface

// File: rtl/i3c_frombus_cdc_fifo.sv
// Bus->system byte FIFO: SCL-domain writes, CLK-domain reads,
// gray pointers, err tag, optional holding reg, trigger and overrun.
module i3c_frombus_cdc_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int ENA_HOLD   = 1,
  parameter int SYNC_STG   = 2
) (
  input  logic                  RSTn,
  input  logic                  CLK,
  input  logic                  SCL,
  i3c_frombus_cdc_fifo_if.slave fb,
  input  logic                  fb_flush,
  output logic [DEPTH_LOG2+1:0] avail_byte_cnt,
  output logic                  avail_fb_empty,
  input  logic [1:0]            rx_trig,
  output logic                  int_rx,
  output logic                  set_fb_orun,
  input  logic                  clear_fb_orun
);
  localparam int P     = DEPTH_LOG2 + 1;
  localparam int CW    = DEPTH_LOG2 + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = DATA_W + 1;
  localparam int TH1   = (DEPTH / 4 > 1) ? DEPTH / 4 : 1;

  typedef logic [P-1:0] ptr_t;

  localparam ptr_t FMASK = ptr_t'(3 << (P - 2));

  function automatic ptr_t b2g(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t g2b(ptr_t g);
    ptr_t b;
    b[P-1] = g[P-1];
    for (int i = P - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [EW-1:0] mem_q [DEPTH];
  ptr_t          wbin_q, wbin_d, wgray_q;
  ptr_t          rbin_q, rbin_d, rgray_q;
  ptr_t          rg_sync_q [SYNC_STG];
  ptr_t          wg_sync_q [SYNC_STG];
  logic          otgl_q;
  logic          full, push;

  // SCL domain: write side
  assign full   = wgray_q == (rg_sync_q[SYNC_STG-1] ^ FMASK);
  assign push   = fb.fb_datab_done & ~full;
  assign wbin_d = push ? wbin_q + ptr_t'(1) : wbin_q;
  assign fb.fb_data_use = ~full;

  always_ff @(posedge SCL or negedge RSTn) begin
    if (!RSTn) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      otgl_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      for (int i = 0; i < SYNC_STG; i++)
        rg_sync_q[i] <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= b2g(wbin_d);
      if (push)
        mem_q[wbin_q[P-2:0]] <= {fb.fb_datab_err, fb.fb_datab};
      if (fb.fb_datab_done & full)
        otgl_q <= ~otgl_q;
      rg_sync_q[0] <= rgray_q;
      for (int i = 1; i < SYNC_STG; i++)
        rg_sync_q[i] <= rg_sync_q[i-1];
    end
  end

  // CLK domain: read side
  ptr_t          wg_s, wbin_s;
  logic          empty;
  logic [EW-1:0] rd_word;
  logic [EW-1:0] hold_q, hold_d;
  logic          hold_v_q, hold_v_d;

  assign wg_s    = wg_sync_q[SYNC_STG-1];
  assign wbin_s  = g2b(wg_s);
  assign empty   = rgray_q == wg_s;
  assign rd_word = mem_q[rbin_q[P-2:0]];

  always_comb begin
    rbin_d   = rbin_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    if (fb_flush) begin
      rbin_d   = wbin_s;
      hold_v_d = 1'b0;
    end else if (ENA_HOLD != 0) begin
      if ((~hold_v_q | fb.notify_fb_ack) & ~empty) begin
        hold_d   = rd_word;
        hold_v_d = 1'b1;
        rbin_d   = rbin_q + ptr_t'(1);
      end else if (fb.notify_fb_ack) begin
        hold_v_d = 1'b0;
      end
    end else if (fb.notify_fb_ack & ~empty) begin
      rbin_d = rbin_q + ptr_t'(1);
    end
  end

  logic [SYNC_STG-1:0] ot_sync_q;
  logic                ot_prev_q, orun_q, ot_edge;

  assign ot_edge = ot_sync_q[SYNC_STG-1] ^ ot_prev_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rbin_q    <= '0;
      rgray_q   <= '0;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      ot_sync_q <= '0;
      ot_prev_q <= 1'b0;
      orun_q    <= 1'b0;
      for (int i = 0; i < SYNC_STG; i++)
        wg_sync_q[i] <= '0;
    end else begin
      rbin_q    <= rbin_d;
      rgray_q   <= b2g(rbin_d);
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      ot_sync_q <= {ot_sync_q[SYNC_STG-2:0], otgl_q};
      ot_prev_q <= ot_sync_q[SYNC_STG-1];
      orun_q    <= ot_edge | (orun_q & ~clear_fb_orun);
      wg_sync_q[0] <= wgray_q;
      for (int i = 1; i < SYNC_STG; i++)
        wg_sync_q[i] <= wg_sync_q[i-1];
    end
  end

  assign fb.notify_fb_ready = (ENA_HOLD != 0) ? hold_v_q : ~empty;
  assign fb.notify_fb_data  = (ENA_HOLD != 0) ? hold_q[DATA_W-1:0]
                                              : rd_word[DATA_W-1:0];
  assign fb.notify_fb_err   = (ENA_HOLD != 0) ? hold_q[DATA_W]
                                              : rd_word[DATA_W];

  logic [CW-1:0] thr;

  assign avail_byte_cnt = {1'b0, ptr_t'(wbin_s - rbin_q)} + CW'(hold_v_q);
  assign avail_fb_empty = empty & ~hold_v_q;
  assign set_fb_orun    = orun_q;

  always_comb begin
    thr = CW'(1);
    unique case (rx_trig)
      2'd0: thr = CW'(1);
      2'd1: thr = CW'(TH1);
      2'd2: thr = CW'(DEPTH / 2);
      2'd3: thr = CW'(DEPTH - 1);
      default: thr = CW'(1);
    endcase
  end

  assign int_rx = avail_byte_cnt >= thr;
endmodule

// File: tb/tb_i3c_frombus_cdc_fifo.sv
// Random push/ack traffic against a queue model of the inbound FIFO,
// plus directed full, overrun, flush, trigger and reset scenarios.
module tb_i3c_frombus_cdc_fifo;
  localparam int DW    = 8;
  localparam int DL    = 3;
  localparam int EH    = 1;
  localparam int SS    = 2;
  localparam int DEPTH = 1 << DL;
  localparam int CAP   = DEPTH + EH;

  logic          CLK = 1'b0;
  logic          SCL = 1'b0;
  logic          RSTn = 1'b0;
  logic          fb_flush = 1'b0;
  logic [DL+1:0] avail_byte_cnt;
  logic          avail_fb_empty;
  logic [1:0]    rx_trig = 2'd0;
  logic          int_rx;
  logic          set_fb_orun;
  logic          clear_fb_orun = 1'b0;

  i3c_frombus_cdc_fifo_if #(.DATA_W(DW)) fb ();

  i3c_frombus_cdc_fifo #(
    .DATA_W(DW), .DEPTH_LOG2(DL),
    .ENA_HOLD(EH), .SYNC_STG(SS)
  ) dut (
    .RSTn(RSTn), .CLK(CLK), .SCL(SCL),
    .fb(fb),
    .fb_flush(fb_flush),
    .avail_byte_cnt(avail_byte_cnt),
    .avail_fb_empty(avail_fb_empty),
    .rx_trig(rx_trig),
    .int_rx(int_rx),
    .set_fb_orun(set_fb_orun),
    .clear_fb_orun(clear_fb_orun)
  );

  initial forever #5 CLK = ~CLK;
  initial begin
    #7;
    forever #15 SCL = ~SCL;
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  int         ack_pct = 0;
  int         drops = 0;
  bit         exp_orun = 1'b0;
  logic [8:0] q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    logic u;
    @(negedge SCL);
    fb.fb_datab      = d;
    fb.fb_datab_err  = e;
    fb.fb_datab_done = 1'b1;
    u = fb.fb_data_use;
    if (u) chk("no_overfill", 32'(q.size() < CAP), 1);
    @(posedge SCL);
    #1 fb.fb_datab_done = 1'b0;
    if (u) q.push_back({e, d});
    else begin
      drops++;
      exp_orun = 1'b1;
    end
  endtask

  task automatic settle();
    repeat (20) @(negedge CLK);
  endtask

  task automatic chk_idle();
    chk("cnt", avail_byte_cnt, q.size());
    chk("empty", avail_fb_empty, q.size() == 0);
    chk("ready", fb.notify_fb_ready, q.size() != 0);
    chk("use", fb.fb_data_use, q.size() < CAP);
    chk("orun", set_fb_orun, exp_orun);
  endtask

  task automatic drain();
    int n = 0;
    ack_pct = 100;
    while (q.size() != 0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    ack_pct = 0;
    settle();
    chk_idle();
  endtask

  task automatic clear_orun();
    @(negedge CLK) clear_fb_orun = 1'b1;
    @(negedge CLK) clear_fb_orun = 1'b0;
    exp_orun = 1'b0;
    chk("orun_clr", set_fb_orun, 0);
  endtask

  // Reader: checks the presented byte against the model head, acks at random
  initial begin
    fb.notify_fb_ack = 1'b0;
    forever begin
      @(negedge CLK);
      if (RSTn && fb.notify_fb_ready) begin
        if (q.size() == 0) chk("rd_spurious", fb.notify_fb_ready, 0);
        else begin
          chk("rd_data", fb.notify_fb_data, q[0][7:0]);
          chk("rd_err", fb.notify_fb_err, q[0][8]);
        end
        if (ack_pct > 0 && $urandom_range(99) < ack_pct) begin
          fb.notify_fb_ack = 1'b1;
          if (q.size() != 0) void'(q.pop_front());
        end else fb.notify_fb_ack = 1'b0;
      end else fb.notify_fb_ack = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, d0;
    int thr [4];
    thr[0] = 1;
    thr[1] = (DEPTH / 4 > 1) ? DEPTH / 4 : 1;
    thr[2] = DEPTH / 2;
    thr[3] = DEPTH - 1;
    fb.fb_datab      = '0;
    fb.fb_datab_err  = 1'b0;
    fb.fb_datab_done = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_use", fb.fb_data_use, 1);
    chk("rst_empty", avail_fb_empty, 1);
    chk("rst_cnt", avail_byte_cnt, 0);
    chk("rst_ready", fb.notify_fb_ready, 0);
    chk("rst_orun", set_fb_orun, 0);
    chk("rst_int", int_rx, 0);
    RSTn = 1'b1;
    settle();

    // Fill to capacity, then one overrun
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i), 1'b0);
    settle();
    chk("full_cnt", avail_byte_cnt, 9);
    chk("full_use", fb.fb_data_use, 0);
    push(8'hAA, 1'b0);
    settle();
    chk("orun_set", set_fb_orun, 1);
    chk_idle();
    clear_orun();
    drain();

    // Err tag and read latency
    push(8'h5A, 1'b1);
    n = 0;
    while (n < 20) begin
      @(posedge CLK);
      n++;
      #1;
      if (fb.notify_fb_ready) break;
    end
    chk("latency", n, SS + EH);
    chk("err_data", fb.notify_fb_data, 8'h5A);
    chk("err_tag", fb.notify_fb_err, 1);
    drain();

    // Streaming with ack every cycle, pointers wrap
    d0 = drops;
    ack_pct = 100;
    for (int i = 0; i < 20; i++) push(8'(i), 1'b0);
    chk("stream_drops", drops - d0, 0);
    drain();

    // Flush
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i), 1'b1);
    settle();
    chk_idle();
    @(negedge CLK) fb_flush = 1'b1;
    @(negedge CLK) fb_flush = 1'b0;
    q.delete();
    chk("flush_cnt", avail_byte_cnt, 0);
    chk("flush_empty", avail_fb_empty, 1);
    chk("flush_ready", fb.notify_fb_ready, 0);
    push(8'h77, 1'b0);
    settle();
    chk("post_flush", fb.notify_fb_data, 8'h77);
    drain();

    // Trigger levels over every fill level
    rx_trig = 2'd2;
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 1'b0);
    settle();
    chk("trig2_cnt3", int_rx, 0);
    push(8'h33, 1'b0);
    settle();
    chk("trig2_cnt4", int_rx, 1);
    drain();
    for (int k = 0; k <= CAP; k++) begin
      if (k > 0) push(8'($urandom), 1'b0);
      settle();
      for (int t = 0; t < 4; t++) begin
        @(negedge CLK) rx_trig = 2'(t);
        #1 chk("int_rx", int_rx, q.size() >= thr[t]);
      end
    end
    drain();

    // Random traffic
    for (int i = 0; i < 250; i++) begin
      if (i % 50 == 0)
        ack_pct = ($urandom_range(3) == 0) ? 0 : $urandom_range(10, 90);
      repeat ($urandom_range(2)) @(negedge SCL);
      push(8'($urandom), 1'($urandom_range(1)));
    end
    drain();
    if (exp_orun) clear_orun();

    // Reset in mid-operation
    for (int i = 0; i < 3; i++) push(8'(8'h50 + i), 1'b0);
    settle();
    @(negedge CLK) RSTn = 1'b0;
    #1;
    q.delete();
    exp_orun = 1'b0;
    chk("mrst_cnt", avail_byte_cnt, 0);
    chk("mrst_empty", avail_fb_empty, 1);
    chk("mrst_ready", fb.notify_fb_ready, 0);
    chk("mrst_use", fb.fb_data_use, 1);
    @(negedge CLK) RSTn = 1'b1;
    push(8'h33, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
